deser_sync_ctrl: RTL and testbench
==================================

# deser_sync_ctrl

Word-alignment and sync controller for the 8-bit serial receive path. It watches the serial bit stream and its per-bit K flag, and finds word boundaries by hunting for a comma pattern. It confirms lock after repeated aligned commas and drops lock on repeated misaligned commas. While locked it emits framed 8-bit words with their K flag. It sits directly behind the serial line and drives the deserializer word interface.

## Interface
- COMMA, 8'hBC, word pattern used for alignment (first-received bit = bit 7)
- SYNC_COUNT, 3, aligned commas needed to declare lock (≥2)
- ERR_LIMIT, 2, consecutive misaligned commas that drop lock (≥1)
- clk  in  1  single clock; all sampling on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- data  in  1  serial bit, MSB-first within a word
- DK  in  1  K flag; meaningful on the final bit (bit 0) of a word
- out  out  8  framed word, valid while out_valid=1
- out_DK  out  1  DK sampled with the final bit of `out`
- out_valid  out  1  one-cycle strobe per framed word (locked only)
- locked  out  1  high in LOCKED state
- sync_lost  out  1  one-cycle pulse on the LOCKED→HUNT transition
- state  out  2  0=HUNT, 1=CHECK, 2=LOCKED (3 unused)

## Operation
- Shift register: sr_next = {sr[6:0], data} on every posedge. Comma match: sr_next==COMMA and DK==1 at the same edge.
- Bit counter cnt 0..7 wraps. A boundary edge is an edge where cnt==7, meaning the edge that shifts bit 0 of a word.
- Comma match in HUNT or CHECK forces cnt←0, so the next bit is bit 7 of a new word.
- HUNT:
  - cnt ignored.
  - Comma match → CHECK, good←1.
- CHECK, evaluated on boundary edges only:
  - Comma match → good+1. If good+1==SYNC_COUNT → LOCKED, bad←0.
  - Any non-comma word → HUNT, good←0.
  - Non-boundary comma match → re-align (cnt←0), good←1, stay CHECK.
- LOCKED:
  - Every boundary edge: out←sr_next, out_DK←DK, out_valid←1.
  - Aligned comma: bad←0.
  - Non-boundary comma match: bad+1. If bad+1==ERR_LIMIT → HUNT, sync_lost←1, good←0, bad←0, cnt held. No realignment occurs in LOCKED.
  - Non-comma data words never affect bad.
- Simultaneous events:
  - Reset dominates everything.
  - A misaligned comma cannot coincide with a boundary edge, by definition.
  - The final word emitted on the HUNT transition edge is dropped (out_valid stays 0).
- Counters good and bad saturate at SYNC_COUNT and ERR_LIMIT respectively and never wrap.

## Timing
- Reset values:
  - out=8'h00, out_DK=0, out_valid=0, locked=0, sync_lost=0.
  - state=HUNT, cnt=0, good=0, bad=0, sr=8'h00.
- All outputs are registered.
  - Word latency: the boundary edge N loads out/out_DK and raises out_valid, visible after N. `out` holds until the next boundary edge.
  - out_valid and sync_lost are high for exactly one cycle.
  - In steady lock, out_valid strobes every 8 cycles.
- locked and state update on the same edge as the transition.
  - The first out_valid in LOCKED is at the first boundary edge after the lock edge, 8 cycles later.
- Reset asserted mid-word: outputs clear asynchronously. After deassert, the block resumes in HUNT at the next posedge.

## Test plan
- Reset: assert reset mid-stream.
  - → All outputs 0 and state=0 without a clock edge.
  - → They stay 0 for 20 cycles of random data with no comma.
- Acquisition: 5 random bits, then three 8'hBC words with DK=1 on each bit 0.
  - → state goes 1 after the first comma and 2 after the third.
  - → locked=1.
  - → 8 cycles later out=8'hBC, out_DK=1, out_valid pulse.
- Locked data: send 8'hA5 then 8'h3C with DK=0.
  - → out_valid pulses exactly 8 cycles apart with out=A5 then 3C, out_DK=0.
  - → No other out_valid pulses.
- CHECK failure: send one comma, then 8'h00.
  - → state 1, then 0 at the 8'h00 boundary edge.
  - → locked and out_valid never assert.
- Loss of sync: while locked, inject 8'hBC shifted by 3 bits, twice.
  - → sync_lost pulses once, state=0, locked=0, out_valid stops.
- Recovery: one misaligned comma, then an aligned comma, then a second misaligned comma.
  - → Stays locked, because the aligned comma resets bad.

Source files
------------

// File: rtl/deser_sync_ctrl.sv
// deser_sync_ctrl: comma-based word aligner and lock controller for the
// 8-bit serial receive path. Bits arrive MSB-first; a comma is the COMMA
// pattern completing on an edge where DK is high.
//
// state  | meaning
// HUNT   | searching every bit offset for a comma
// CHECK  | comma seen; confirming further commas land on word boundaries
// LOCKED | aligned; emitting framed words, counting misaligned commas
module deser_sync_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_COUNT = 3,
    parameter int         ERR_LIMIT  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data,
    input  logic       DK,
    output logic [7:0] out,
    output logic       out_DK,
    output logic       out_valid,
    output logic       locked,
    output logic       sync_lost,
    output logic [1:0] state
);
    localparam int GW = $clog2(SYNC_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [GW:0] GOOD_MAX = (GW + 1)'(SYNC_COUNT);
    localparam logic [EW:0] BAD_MAX  = (EW + 1)'(ERR_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    cnt_q, cnt_n;
    logic [GW-1:0] good_q, good_n;
    logic [EW-1:0] bad_q, bad_n;
    logic [7:0]    sr_q, sr_next;
    logic [GW:0]   good_inc;
    logic [EW:0]   bad_inc;
    logic          comma, boundary;
    logic [7:0]    out_n;
    logic          out_dk_n, valid_n, lost_n;

    assign state = state_q;

    // Next-state, counter and framed-output decisions for the current bit
    always_comb begin
        sr_next  = {sr_q[6:0], data};
        comma    = (sr_next == COMMA) && DK;
        boundary = (cnt_q == 3'd7);
        good_inc = {1'b0, good_q} + {{GW{1'b0}}, 1'b1};
        bad_inc  = {1'b0, bad_q} + {{EW{1'b0}}, 1'b1};

        state_n  = state_q;
        cnt_n    = cnt_q + 3'd1;
        good_n   = good_q;
        bad_n    = bad_q;
        out_n    = out;
        out_dk_n = out_DK;
        valid_n  = 1'b0;
        lost_n   = 1'b0;

        case (state_q)
            HUNT: begin
                if (comma) begin
                    state_n = CHECK;
                    good_n  = GW'(1);
                    cnt_n   = 3'd0;
                end
            end
            CHECK: begin
                if (comma) begin
                    cnt_n = 3'd0;
                    if (boundary) begin
                        if (good_inc >= GOOD_MAX) begin
                            state_n = LOCKED;
                            good_n  = GOOD_MAX[GW-1:0];
                            bad_n   = EW'(0);
                        end else begin
                            good_n = good_inc[GW-1:0];
                        end
                    end else begin
                        // comma at a new offset: restart confirmation there
                        good_n = GW'(1);
                    end
                end else if (boundary) begin
                    state_n = HUNT;
                    good_n  = GW'(0);
                end
            end
            LOCKED: begin
                if (boundary) begin
                    out_n    = sr_next;
                    out_dk_n = DK;
                    valid_n  = 1'b1;
                    if (comma) begin
                        bad_n = EW'(0);
                    end
                end else if (comma) begin
                    // no realignment while locked; only count the offense
                    if (bad_inc >= BAD_MAX) begin
                        state_n = HUNT;
                        lost_n  = 1'b1;
                        good_n  = GW'(0);
                        bad_n   = EW'(0);
                        cnt_n   = cnt_q;
                    end else begin
                        bad_n = bad_inc[EW-1:0];
                    end
                end
            end
            default: begin
                state_n = HUNT;
                good_n  = GW'(0);
                bad_n   = EW'(0);
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            cnt_q     <= 3'd0;
            good_q    <= GW'(0);
            bad_q     <= EW'(0);
            sr_q      <= 8'h00;
            out       <= 8'h00;
            out_DK    <= 1'b0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            good_q    <= good_n;
            bad_q     <= bad_n;
            sr_q      <= sr_next;
            out       <= out_n;
            out_DK    <= out_dk_n;
            out_valid <= valid_n;
            locked    <= (state_n == LOCKED);
            sync_lost <= lost_n;
        end
    end

endmodule

// File: tb/tb_deser_sync_ctrl.sv
// Testbench for deser_sync_ctrl: scoreboard of framed words plus
// table-driven locked data and hand-written lock/loss sequences.
module tb_deser_sync_ctrl;
    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk = 1'b0;
    logic       reset;
    logic       data;
    logic       DK;
    logic [7:0] out;
    logic       out_DK;
    logic       out_valid;
    logic       locked;
    logic       sync_lost;
    logic [1:0] state;

    deser_sync_ctrl #(
        .COMMA(COMMA),
        .SYNC_COUNT(3),
        .ERR_LIMIT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data(data),
        .DK(DK),
        .out(out),
        .out_DK(out_DK),
        .out_valid(out_valid),
        .locked(locked),
        .sync_lost(sync_lost),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic       dk;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] word;
        logic       dk;
        logic [7:0] exp_out;
        logic       exp_dk;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[6];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       exp_lock = 1'b0;
    int         phase = 0;
    logic [7:0] tb_sr = 8'h00;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one bit, predict a framed word when the bench knows it is aligned
    task automatic send_bit(input logic d, input logic k);
        exp_t e;
        data  = d;
        DK    = k;
        tb_sr = {tb_sr[6:0], d};
        if (exp_lock && phase == 7) begin
            e.word = tb_sr;
            e.dk   = k;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        phase = (phase + 1) % 8;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic k);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], (i == 0) ? k : 1'b0);
        end
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic pad_to_boundary();
        while (phase != 0) begin
            send_bit(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic acquire();
        send_random(5);
        send_word(COMMA, 1'b1);
        check("acq_state_1st", 16'(state), 16'd1);
        send_word(COMMA, 1'b1);
        check("acq_state_2nd", 16'(state), 16'd1);
        send_word(COMMA, 1'b1);
        check("acq_state_3rd", 16'(state), 16'd2);
        check("acq_locked", 16'(locked), 16'd1);
        exp_lock = 1'b1;
        phase    = 0;
    endtask

    task automatic misaligned_comma();
        send_random(3);
        send_word(COMMA, 1'b1);
    endtask

    // Scoreboard: every out_valid must match the oldest predicted word and cycle
    always begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: out=%0h out_DK=%0b at cycle %0d, none expected", out, out_DK, cyc);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || out !== e.word || out_DK !== e.dk) begin
                    errors++;
                    $display("FAIL word: got out=%0h dk=%0b cycle %0d expected out=%0h dk=%0b cycle %0d",
                             out, out_DK, cyc, e.word, e.dk, e.cyc);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_valid: got no word at cycle %0d expected out=%0h dk=%0b", cyc, e.word, e.dk);
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[2] = '{8'hBC, 1'b0, 8'hBC, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1'b1};

        reset = 1'b1;
        data  = 1'b0;
        DK    = 1'b0;
        #1;
        check("reset_outputs", 16'({out, out_DK, out_valid, locked, sync_lost, state}), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Acquisition, then the first framed word 8 cycles after lock
        acquire();
        send_word(COMMA, 1'b1);
        check("first_word_valid", 16'(out_valid), 16'd1);
        check("first_word_out", 16'(out), 16'h00BC);
        check("first_word_dk", 16'(out_DK), 16'd1);

        // Locked data from the vector table
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].word, vecs[i].dk);
            check("tbl_out", 16'(out), 16'(vecs[i].exp_out));
            check("tbl_dk", 16'(out_DK), 16'(vecs[i].exp_dk));
            check("tbl_valid", 16'(out_valid), 16'd1);
            check("tbl_state", 16'(state), 16'd2);
        end

        // Loss of sync: two consecutive misaligned commas
        pad_to_boundary();
        misaligned_comma();
        check("loss1_locked", 16'(locked), 16'd1);
        check("loss1_sync_lost", 16'(sync_lost), 16'd0);
        misaligned_comma();
        exp_lock = 1'b0;
        check("loss2_sync_lost", 16'(sync_lost), 16'd1);
        check("loss2_state", 16'(state), 16'd0);
        check("loss2_locked", 16'(locked), 16'd0);
        send_random(1);
        check("sync_lost_pulse", 16'(sync_lost), 16'd0);
        for (int i = 0; i < 16; i++) begin
            send_random(1);
            check("lost_no_valid", 16'(out_valid), 16'd0);
        end

        // Recovery: an aligned comma between misaligned ones clears bad
        acquire();
        misaligned_comma();
        pad_to_boundary();
        send_word(COMMA, 1'b1);
        misaligned_comma();
        check("recov_locked", 16'(locked), 16'd1);
        check("recov_state", 16'(state), 16'd2);
        check("recov_sync_lost", 16'(sync_lost), 16'd0);
        pad_to_boundary();
        send_word(vecs[5].word, vecs[5].dk);
        check("recov_out", 16'(out), 16'(vecs[5].exp_out));

        // Mid-word asynchronous reset while locked
        send_random(3);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 16'({out, out_DK, out_valid, locked, sync_lost, state}), 16'd0);
        exp_lock = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send_random(1);
            check("post_reset_idle", 16'({out, out_DK, out_valid, locked, sync_lost, state}), 16'd0);
        end

        // CHECK failure: one comma then a non-comma word
        send_word(COMMA, 1'b1);
        check("chkfail_state_check", 16'(state), 16'd1);
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b0, 1'b0);
            check("chkfail_state", 16'(state), (i > 0) ? 16'd1 : 16'd0);
            check("chkfail_locked", 16'(locked), 16'd0);
        end

        send_random(10);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
